// File: rtl/fifo_pkt_pkg.sv
// Shared types and default widths for the FIFO packet reader.
// Header word layout: [DATA_WIDTH-1:LEN_WIDTH] = tag, [LEN_WIDTH-1:0] = payload length.
// Optional trailing checksum word is enabled with PKT_CHECKSUM_EN.
package fifo_pkt_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 10;
    localparam int DEF_TAG_WIDTH  = 6;
    localparam int DEF_CNT_WIDTH  = 16;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = DEF_LEN_WIDTH - 1;
    localparam int HDR_TAG_LSB = DEF_LEN_WIDTH;
    localparam int HDR_TAG_MSB = DEF_DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_packet_reader.sv
// Parses FWFT FIFO words (header + LEN payload words) into a sop/eop/tag framed stream.
// Latency: FIFO head to out_data is 1 cycle; header consumes one cycle and is never forwarded.
// Backpressure: payload pops only when the output register can load; out_ready=0 holds the beat.
// Optional PKT_CHECKSUM_EN: trailing XOR checksum word is popped, checked, flagged on err_checksum.
module fifo_packet_reader
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clock_read,
    input  logic                  read_reset,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [CNT_WIDTH-1:0]  pkt_count,
`ifdef PKT_CHECKSUM_EN
    output logic                  err_checksum,
`endif
    output logic                  err_zero_len
);

    state_t                 state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   first_beat;
    logic                   load;
    logic                   payload_pop;
    logic [LEN_WIDTH-1:0]   hdr_len;
    logic [TAG_WIDTH-1:0]   hdr_tag;
`ifdef PKT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  acc;
`endif

    assign load        = !out_valid | out_ready;
    assign hdr_len     = fifo_read_data[LEN_WIDTH-1:0];
    assign hdr_tag     = fifo_read_data[DATA_WIDTH-1:LEN_WIDTH];
    assign payload_pop = (state == PAYLOAD) && fifo_read_enable;

    // Pop decision: headers/checksums pop freely, payload only when the output register can take it.
    always_comb begin
        fifo_read_enable = 1'b0;
        if (!read_reset) begin
            case (state)
                IDLE:    fifo_read_enable = !fifo_empty;
                PAYLOAD: fifo_read_enable = !fifo_empty & load;
`ifdef PKT_CHECKSUM_EN
                CHECK:   fifo_read_enable = !fifo_empty;
`endif
                default: fifo_read_enable = 1'b0;
            endcase
        end
    end

    // Packet framing FSM: header parse, payload countdown, optional checksum check.
    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) begin
            state        <= IDLE;
            remaining    <= '0;
            tag_q        <= '0;
            first_beat   <= 1'b0;
            err_zero_len <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            acc          <= '0;
            err_checksum <= 1'b0;
`endif
        end else begin
            err_zero_len <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            err_checksum <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fifo_read_enable) begin
                        tag_q     <= hdr_tag;
                        remaining <= hdr_len;
`ifdef PKT_CHECKSUM_EN
                        acc       <= fifo_read_data;
`endif
                        if (hdr_len == '0) begin
                            err_zero_len <= 1'b1;
                        end else begin
                            first_beat <= 1'b1;
                            state      <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (fifo_read_enable) begin
                        first_beat <= 1'b0;
                        remaining  <= remaining - LEN_WIDTH'(1);
`ifdef PKT_CHECKSUM_EN
                        acc        <= acc ^ fifo_read_data;
                        if (remaining == LEN_WIDTH'(1)) state <= CHECK;
`else
                        if (remaining == LEN_WIDTH'(1)) state <= IDLE;
`endif
                    end
                end
`ifdef PKT_CHECKSUM_EN
                CHECK: begin
                    if (fifo_read_enable) begin
                        err_checksum <= (fifo_read_data != acc);
                        state        <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: loads on payload pops, drains when the sink takes the beat, else holds.
    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_tag   <= '0;
        end else if (payload_pop) begin
            out_data  <= fifo_read_data;
            out_valid <= 1'b1;
            out_sop   <= first_beat;
            out_eop   <= (remaining == LEN_WIDTH'(1));
            out_tag   <= tag_q;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

    // Completed-packet counter, wraps naturally at its width.
    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) begin
            pkt_count <= '0;
        end else if (out_valid && out_ready && out_eop) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Directed bench for fifo_packet_reader: FWFT FIFO model, per-cycle vector table, beat scoreboard.
// Build with PKT_CHECKSUM_EN defined to also cover the checksum word handling.
module tb_fifo_packet_reader;

    logic        clock_read = 1'b0;
    logic        read_reset;
    logic [15:0] fifo_read_data;
    logic        fifo_empty;
    logic        fifo_read_enable;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [5:0]  out_tag;
    logic [15:0] pkt_count;
    logic        err_zero_len;
`ifdef PKT_CHECKSUM_EN
    logic        err_checksum;
`endif

    fifo_packet_reader dut (
        .clock_read       (clock_read),
        .read_reset       (read_reset),
        .fifo_read_data   (fifo_read_data),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sop          (out_sop),
        .out_eop          (out_eop),
        .out_tag          (out_tag),
        .pkt_count        (pkt_count),
`ifdef PKT_CHECKSUM_EN
        .err_checksum     (err_checksum),
`endif
        .err_zero_len     (err_zero_len)
    );

    always #5 clock_read = ~clock_read;

    typedef struct {
        logic [15:0] dat;
        logic        sop;
        logic        eop;
        logic [5:0]  tag;
    } beat_t;

    typedef struct {
        logic        rdy;
        logic        fre;
        logic        vld;
        logic [15:0] dat;
        logic        sop;
        logic        eop;
        logic [5:0]  tag;
        logic [15:0] cnt;
    } vec_t;

    logic [15:0] fq[$];
    beat_t       beats[$];
    logic        gap;
    logic        did_pop;
    int          n_checks;
    int          n_fail;
    int          zl_pulses;
    int          cs_pulses;
    logic [15:0] exp_cnt;
    vec_t        vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        fifo_empty     = gap || (fq.size() == 0);
        fifo_read_data = (fq.size() != 0) ? fq[0] : 16'h0000;
        #1;
        did_pop = fifo_read_enable;
        check("no_pop_when_empty", {31'd0, fifo_read_enable & fifo_empty}, 32'd0);
        if (out_valid && out_ready) beats.push_back('{out_data, out_sop, out_eop, out_tag});
        @(posedge clock_read);
        if (did_pop && fq.size() != 0) void'(fq.pop_front());
        @(negedge clock_read);
        zl_pulses += int'(err_zero_len);
`ifdef PKT_CHECKSUM_EN
        cs_pulses += int'(err_checksum);
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_beat(input string name, input int idx, input logic [15:0] dat,
                              input logic sop, input logic eop, input logic [5:0] tag);
        if (beats.size() > idx) begin
            check({name, "_dat"}, {16'd0, beats[idx].dat}, {16'd0, dat});
            check({name, "_sop"}, {31'd0, beats[idx].sop}, {31'd0, sop});
            check({name, "_eop"}, {31'd0, beats[idx].eop}, {31'd0, eop});
            check({name, "_tag"}, {26'd0, beats[idx].tag}, {26'd0, tag});
        end else begin
            check({name, "_missing"}, beats.size(), idx + 1);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        zl_pulses = 0;
        cs_pulses = 0;
        gap       = 1'b0;
        did_pop   = 1'b0;
        out_ready = 1'b1;
        read_reset = 1'b1;
        fifo_empty = 1'b0;
        fifo_read_data = 16'h0C03;

        // Basic packet, per-cycle expectations (fre sampled before the edge, rest after it).
        vt[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'd0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 16'hA001, 1'b1, 1'b0, 6'd3, 16'd0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 16'hA002, 1'b0, 1'b0, 6'd3, 16'd0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 16'hA003, 1'b0, 1'b1, 6'd3, 16'd0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'd0, 16'd1};

        // Reset state, with a non-empty FIFO that must not be popped.
        repeat (2) @(negedge clock_read);
        check("rst_fre",   {31'd0, fifo_read_enable}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cnt",   {16'd0, pkt_count}, 32'd0);
        check("rst_zl",    {31'd0, err_zero_len}, 32'd0);
        read_reset = 1'b0;
        fifo_empty = 1'b1;
        @(negedge clock_read);

        // Basic packet from the vector table.
        fq = '{16'h0C03, 16'hA001, 16'hA002, 16'hA003};
        for (int i = 0; i < 5; i++) begin
            out_ready = vt[i].rdy;
            step();
            check($sformatf("basic%0d_fre", i), {31'd0, did_pop}, {31'd0, vt[i].fre});
            check($sformatf("basic%0d_vld", i), {31'd0, out_valid}, {31'd0, vt[i].vld});
            if (vt[i].vld) begin
                check($sformatf("basic%0d_dat", i), {16'd0, out_data}, {16'd0, vt[i].dat});
                check($sformatf("basic%0d_sop", i), {31'd0, out_sop}, {31'd0, vt[i].sop});
                check($sformatf("basic%0d_eop", i), {31'd0, out_eop}, {31'd0, vt[i].eop});
                check($sformatf("basic%0d_tag", i), {26'd0, out_tag}, {26'd0, vt[i].tag});
            end
            check($sformatf("basic%0d_cnt", i), {16'd0, pkt_count}, {16'd0, vt[i].cnt});
        end
        exp_cnt = 16'd1;

        // Backpressure: stall 5 cycles with A001 pending.
        beats.delete();
        fq = '{16'h0C03, 16'hA001, 16'hA002, 16'hA003};
        out_ready = 1'b1;
        steps(2);
        check("bp_first_vld", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_stall_pop",  {31'd0, did_pop}, 32'd0);
            check("bp_stall_hold", {16'd0, out_data}, 32'h0000A001);
        end
        out_ready = 1'b1;
        steps(6);
        exp_cnt++;
        check("bp_nbeats", beats.size(), 3);
        check_beat("bp_b0", 0, 16'hA001, 1'b1, 1'b0, 6'd3);
        check_beat("bp_b1", 1, 16'hA002, 1'b0, 1'b0, 6'd3);
        check_beat("bp_b2", 2, 16'hA003, 1'b0, 1'b1, 6'd3);
        check("bp_cnt", {16'd0, pkt_count}, {16'd0, exp_cnt});

        // Zero-length header then a one-word packet.
        beats.delete();
        zl_pulses = 0;
        fq = '{16'h0400, 16'h0401, 16'hBEEF};
        steps(6);
        exp_cnt++;
        check("zl_pulses", zl_pulses, 1);
        check("zl_nbeats", beats.size(), 1);
        check_beat("zl_b0", 0, 16'hBEEF, 1'b1, 1'b1, 6'd1);
        check("zl_cnt", {16'd0, pkt_count}, {16'd0, exp_cnt});

        // Underflow mid-packet.
        beats.delete();
        fq = '{16'h0002, 16'h1111};
        steps(2);
        check("uf_first_vld", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("uf_gap_vld", {31'd0, out_valid}, 32'd0);
        end
        fq.push_back(16'h2222);
        steps(4);
        exp_cnt++;
        check("uf_nbeats", beats.size(), 2);
        check_beat("uf_b0", 0, 16'h1111, 1'b1, 1'b0, 6'd0);
        check_beat("uf_b1", 1, 16'h2222, 1'b0, 1'b1, 6'd0);
        check("uf_cnt", {16'd0, pkt_count}, {16'd0, exp_cnt});

        // Reset after the first payload beat of a LEN=5 packet.
        beats.delete();
        fq = '{16'h0005, 16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005};
        out_ready = 1'b0;
        steps(2);
        check("mr_pre_vld", {31'd0, out_valid}, 32'd1);
        #2 read_reset = 1'b1;
        #1;
        check("mr_vld",  {31'd0, out_valid}, 32'd0);
        check("mr_dat",  {16'd0, out_data}, 32'd0);
        check("mr_sop",  {31'd0, out_sop}, 32'd0);
        check("mr_tag",  {26'd0, out_tag}, 32'd0);
        check("mr_cnt",  {16'd0, pkt_count}, 32'd0);
        check("mr_fre",  {31'd0, fifo_read_enable}, 32'd0);
        fq.delete();
        @(negedge clock_read);
        read_reset = 1'b0;
        out_ready  = 1'b1;
        beats.delete();
        fq = '{16'h0801, 16'h7777};
        steps(5);
        exp_cnt = 16'd1;
        check("mr_nbeats", beats.size(), 1);
        check_beat("mr_b0", 0, 16'h7777, 1'b1, 1'b1, 6'd2);
        check("mr_cnt_after", {16'd0, pkt_count}, {16'd0, exp_cnt});

`ifdef PKT_CHECKSUM_EN
        // Good and bad checksum words; neither is forwarded.
        beats.delete();
        cs_pulses = 0;
        fq = '{16'h0001, 16'h00FF, 16'h00FE};
        steps(6);
        exp_cnt++;
        check("cs_good_pulses", cs_pulses, 0);
        check("cs_good_nbeats", beats.size(), 1);
        check_beat("cs_good_b0", 0, 16'h00FF, 1'b1, 1'b1, 6'd0);
        beats.delete();
        fq = '{16'h0001, 16'h00FF, 16'h0000};
        steps(6);
        exp_cnt++;
        check("cs_bad_pulses", cs_pulses, 1);
        check("cs_bad_nbeats", beats.size(), 1);
        check_beat("cs_bad_b0", 0, 16'h00FF, 1'b1, 1'b1, 6'd0);
        check("cs_cnt", {16'd0, pkt_count}, {16'd0, exp_cnt});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
